// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared definitions for the HDMI source scheduler.
//   BPC_DEFAULT / PIX_W  default colour depth and resulting pixel width
//   BLANK_DEFAULT        default colour driven when no source owns the display
//   state_t              scheduler states
//   pix_lo()             low bit of slice k in a packed bus of w-bit pixels
package hdmi_pkg;

  localparam int BPC_DEFAULT = 8;
  localparam int PIX_W = 3 * BPC_DEFAULT;
  localparam logic [PIX_W-1:0] BLANK_DEFAULT = 24'h000000;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  function automatic int pix_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/hdmi_src_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req  in   N   request vector
//   ptr  in   IW  index searched first; search wraps upward from here
//   gnt  out  N   one-hot winner, zero when nothing is requesting
//   idx  out  IW  index of the winner (0 when gnt is zero)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic        found;
    logic [IW:0] cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // ptr + i modulo N, kept one bit wider so the wrap compare is exact
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found              = 1'b1;
        gnt[cand[IW-1:0]]  = 1'b1;
        idx                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/hdmi_src_sched.sv
// hdmi_src_sched: routes the encoder's pixel-request strobes and the returned
// pixel to one of NSRC sources. Ownership changes only on a frame-start strobe,
// by round-robin with a minimum hold of HOLD_FRAMES frames.
//   i_pixclk, i_reset_n            clock, synchronous active-low reset
//   i_rd, i_newline, i_newframe    encoder strobes
//   o_pixel                        pixel back to the encoder
//   i_req, i_pixel                 per-source ownership requests and pixels
//   o_rd, o_newline, o_newframe    per-source strobes
//   o_grant, o_active              registered owner (one-hot) / owner present
//   o_frame_cnt                    frame-start count since reset, wraps
//
// state | meaning
// IDLE  | no owner, blank colour driven
// OWNED | grant_q holds the one-hot owner
module hdmi_src_sched
  import hdmi_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int BPC = 8,
  parameter int HOLD_FRAMES = 1,
  parameter logic [3*BPC-1:0] BLANK_COLOR = (3*BPC)'(BLANK_DEFAULT)
) (
  input  logic                   i_pixclk,
  input  logic                   i_reset_n,
  input  logic                   i_rd,
  input  logic                   i_newline,
  input  logic                   i_newframe,
  output logic [3*BPC-1:0]       o_pixel,
  input  logic [NSRC-1:0]        i_req,
  input  logic [NSRC*3*BPC-1:0]  i_pixel,
  output logic [NSRC-1:0]        o_rd,
  output logic [NSRC-1:0]        o_newline,
  output logic [NSRC-1:0]        o_newframe,
  output logic [NSRC-1:0]        o_grant,
  output logic                   o_active,
  output logic [15:0]            o_frame_cnt
);

  localparam int PW = 3 * BPC;
  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t          state_q, state_d;
  logic [NSRC-1:0] grant_q, grant_d, sel, arb_gnt;
  logic [7:0]      hold_cnt, hold_d;
  logic [IW-1:0]   rr_ptr, ptr_d, arb_idx, idx_inc;
  logic [15:0]     frame_cnt;

  rr_arbiter #(.N(NSRC), .IW(IW)) u_arb (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Next search starts one above the new owner, so the owner is searched last.
  assign idx_inc = (arb_idx == IW'(NSRC - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      hold_cnt  <= '0;
      rr_ptr    <= '0;
      frame_cnt <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      hold_cnt <= hold_d;
      rr_ptr   <= ptr_d;
      if (i_newframe) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_cnt;
    ptr_d   = rr_ptr;
    if (i_newframe) begin
      case (state_q)
        IDLE: begin
          if (|i_req) begin
            state_d = OWNED;
            grant_d = arb_gnt;
            hold_d  = '0;
            ptr_d   = idx_inc;
          end
        end
        OWNED: begin
          if ((|(i_req & grant_q)) && (hold_cnt < HOLD_LAST)) begin
            hold_d = hold_cnt + 8'd1;
          end else if (|arb_gnt) begin
            grant_d = arb_gnt;
            hold_d  = '0;
            ptr_d   = idx_inc;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  // In a frame-start cycle the incoming owner is selected so it sees that strobe.
  always_comb begin
    sel = i_newframe ? grant_d : grant_q;
    o_rd       = {NSRC{i_rd}} & sel;
    o_newline  = {NSRC{i_newline}} & sel;
    o_newframe = {NSRC{i_newframe}} & sel;
    o_pixel    = BLANK_COLOR;
    for (int k = 0; k < NSRC; k++) begin
      if (sel[k]) o_pixel = i_pixel[pix_lo(k, PW) +: PW];
    end
  end

  assign o_grant     = grant_q;
  assign o_active    = (state_q == OWNED);
  assign o_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_hdmi_src_sched.sv
module tb_hdmi_src_sched;

  localparam int NSRC = 4;
  localparam int BPC = 8;
  localparam int PW = 3 * BPC;
  localparam int HOLD = 2;
  localparam logic [PW-1:0] BLANK = 24'h000000;

  logic                  i_pixclk = 1'b0;
  logic                  i_reset_n;
  logic                  i_rd, i_newline, i_newframe;
  logic [PW-1:0]         o_pixel;
  logic [NSRC-1:0]       i_req;
  logic [NSRC*PW-1:0]    i_pixel;
  logic [NSRC-1:0]       o_rd, o_newline, o_newframe, o_grant;
  logic                  o_active;
  logic [15:0]           o_frame_cnt;

  always #5 i_pixclk = ~i_pixclk;

  hdmi_src_sched #(
    .NSRC(NSRC), .BPC(BPC), .HOLD_FRAMES(HOLD), .BLANK_COLOR(BLANK)
  ) dut (
    .i_pixclk   (i_pixclk),
    .i_reset_n  (i_reset_n),
    .i_rd       (i_rd),
    .i_newline  (i_newline),
    .i_newframe (i_newframe),
    .o_pixel    (o_pixel),
    .i_req      (i_req),
    .i_pixel    (i_pixel),
    .o_rd       (o_rd),
    .o_newline  (o_newline),
    .o_newframe (o_newframe),
    .o_grant    (o_grant),
    .o_active   (o_active),
    .o_frame_cnt(o_frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = nobody), frames held, next search start.
  int m_owner, m_hold, m_ptr, m_fcnt;
  int d_owner, d_hold, d_ptr;

  typedef struct {
    logic          rst_n, rd, nl, nf;
    logic [3:0]    req;
    logic [3:0]    sel;
    logic [3:0]    grant;
    logic [15:0]   fcnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic rd, input logic nl, input logic nf,
                     input logic [3:0] req, input logic [3:0] sel,
                     input logic [3:0] g, input logic [15:0] f);
    vec_t v;
    v.rst_n = r; v.rd = rd; v.nl = nl; v.nf = nf;
    v.req = req; v.sel = sel; v.grant = g; v.fcnt = f;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] pixel_of(input logic [3:0] s);
    logic [PW-1:0] p;
    p = BLANK;
    for (int k = 0; k < NSRC; k++) if (s[k]) p = i_pixel[k*PW +: PW];
    return p;
  endfunction

  task automatic check_outputs(input string tag, input logic [3:0] s,
                               input logic [3:0] g, input logic [15:0] f);
    cmp({tag, ".rd"},      32'(o_rd),        32'(i_rd ? s : 4'b0));
    cmp({tag, ".newline"}, 32'(o_newline),   32'(i_newline ? s : 4'b0));
    cmp({tag, ".newframe"},32'(o_newframe),  32'(i_newframe ? s : 4'b0));
    cmp({tag, ".pixel"},   32'(o_pixel),     32'(pixel_of(s)));
    cmp({tag, ".grant"},   32'(o_grant),     32'(g));
    cmp({tag, ".active"},  32'(o_active),    32'(g != 4'b0));
    cmp({tag, ".frame"},   32'(o_frame_cnt), 32'(f));
  endtask

  task automatic model_decide();
    d_owner = m_owner; d_hold = m_hold; d_ptr = m_ptr;
    if (i_newframe) begin
      if (m_owner >= 0 && i_req[m_owner] && m_hold < HOLD - 1) begin
        d_hold = m_hold + 1;
      end else begin
        d_owner = -1;
        d_hold  = 0;
        for (int i = 0; i < NSRC; i++) begin
          int c;
          c = (m_ptr + i) % NSRC;
          if (d_owner < 0 && i_req[c]) begin
            d_owner = c;
            d_ptr   = (c + 1) % NSRC;
          end
        end
      end
    end
  endtask

  task automatic model_step();
    model_decide();
    if (!i_reset_n) begin
      m_owner = -1; m_hold = 0; m_ptr = 0; m_fcnt = 0;
    end else begin
      m_owner = d_owner; m_hold = d_hold; m_ptr = d_ptr;
      if (i_newframe) m_fcnt = (m_fcnt + 1) % 65536;
    end
  endtask

  task automatic check_model(input string tag);
    model_decide();
    check_outputs(tag, i_newframe ? onehot(d_owner) : onehot(m_owner),
                  onehot(m_owner), 16'(m_fcnt));
  endtask

  task automatic tick(input bit chk, input string tag);
    @(negedge i_pixclk);
    if (chk) check_model(tag);
    @(posedge i_pixclk);
    model_step();
    #1;
  endtask

  initial begin
    i_reset_n = 1'b0; i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;
    i_req = '0;
    i_pixel = {24'hD00004, 24'hC00003, 24'hB00002, 24'hA00001};
    m_owner = -1; m_hold = 0; m_ptr = 0; m_fcnt = 0;
    tick(0, "init");
    tick(0, "init");

    //   rst rd nl nf  req      sel      grant    frames
    add(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 2);
    add(1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3);
    add(1, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 3);
    add(1, 1, 0, 1, 4'b0001, 4'b0001, 4'b0000, 3);
    add(1, 1, 1, 0, 4'b0001, 4'b0001, 4'b0001, 4);
    add(1, 0, 0, 1, 4'b0101, 4'b0001, 4'b0001, 4);
    add(1, 1, 0, 0, 4'b0101, 4'b0001, 4'b0001, 5);
    add(1, 1, 0, 1, 4'b0101, 4'b0100, 4'b0001, 5);
    add(1, 1, 0, 0, 4'b0101, 4'b0100, 4'b0100, 6);
    add(1, 0, 0, 1, 4'b0101, 4'b0100, 4'b0100, 6);
    add(1, 1, 1, 1, 4'b0101, 4'b0001, 4'b0100, 7);
    add(1, 1, 0, 0, 4'b0101, 4'b0001, 4'b0001, 8);
    add(1, 0, 0, 1, 4'b0010, 4'b0010, 4'b0001, 8);
    add(1, 1, 0, 0, 4'b0010, 4'b0010, 4'b0010, 9);
    add(1, 1, 1, 0, 4'b1000, 4'b0010, 4'b0010, 9);
    add(1, 1, 0, 1, 4'b1000, 4'b1000, 4'b0010, 9);
    add(1, 1, 0, 0, 4'b0000, 4'b1000, 4'b1000, 10);
    add(1, 0, 0, 1, 4'b0000, 4'b0000, 4'b1000, 10);
    add(1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 11);
    add(1, 0, 0, 1, 4'b0100, 4'b0100, 4'b0000, 11);
    add(1, 1, 0, 0, 4'b0100, 4'b0100, 4'b0100, 12);
    add(0, 1, 0, 0, 4'b0100, 4'b0100, 4'b0100, 12);
    add(1, 1, 0, 0, 4'b0101, 4'b0000, 4'b0000, 0);
    add(1, 0, 0, 1, 4'b0101, 4'b0001, 4'b0000, 0);
    add(1, 1, 0, 0, 4'b0101, 4'b0001, 4'b0001, 1);

    foreach (tbl[i]) begin
      i_reset_n  = tbl[i].rst_n;
      i_rd       = tbl[i].rd;
      i_newline  = tbl[i].nl;
      i_newframe = tbl[i].nf;
      i_req      = tbl[i].req;
      @(negedge i_pixclk);
      check_outputs($sformatf("vec%0d", i), tbl[i].sel, tbl[i].grant, tbl[i].fcnt);
      @(posedge i_pixclk);
      model_step();
      #1;
    end

    // Randomised traffic against the reference model.
    i_reset_n = 1'b0; i_newframe = 1'b0;
    tick(1, "rand_rst");
    for (int n = 0; n < 3000; n++) begin
      i_reset_n  = ($urandom_range(63) != 0);
      i_newframe = i_reset_n && ($urandom_range(7) == 0);
      i_rd       = 1'($urandom_range(1));
      i_newline  = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) i_req = 4'($urandom_range(15));
      for (int k = 0; k < NSRC; k++) i_pixel[k*PW +: PW] = 24'($urandom);
      tick(1, "rand");
    end

    // Frame counter wrap with a steady owner.
    i_reset_n = 1'b0; i_newframe = 1'b0; i_rd = 1'b1; i_newline = 1'b0;
    i_req = 4'b0001;
    tick(0, "wrap_rst");
    i_reset_n = 1'b1; i_newframe = 1'b1;
    for (int n = 0; n < 65536; n++) tick(0, "wrap");
    i_newframe = 1'b0;
    @(negedge i_pixclk);
    cmp("wrap.frame", 32'(o_frame_cnt), 32'h0000);
    cmp("wrap.grant", 32'(o_grant), 32'h1);
    check_model("wrap");
    @(posedge i_pixclk);
    model_step();
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
